multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Parametrised, width-generic ALU for the CSE141L datapath. Single-cycle ops complete in one clock. MUL (shift-add) and DIV (restoring) iterate over W cycles behind a start/ready/valid handshake. Sits between the register-file read ports and write-back, and decodes the shared 4-bit opcode set (SUB, ADD, DIV, MUL, XOR, LSH, RSH, AND, …).

## Interface
Parameters:
- W, 8, operand/result width (≥ 2)
- CW, $clog2(W+1), iteration-counter width (derived; not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when ready=1
- op  in  4  opcode (op_mne from alu_pkg)
- a  in  W  operand A (dividend / multiplicand)
- b  in  W  operand B (divisor / multiplier / shift amount)
- ready  out  1  idle, can accept start
- valid  out  1  one-cycle pulse, results valid
- result  out  W  low word / quotient
- result_hi  out  W  MUL high word / DIV remainder, else 0
- carry  out  1  ADD carry-out; SUB borrow (a<b); else 0
- zero  out  1  result==0 (low word only)
- div0  out  1  DIV with b==0

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready=1. start=1 latches op/a/b. MUL, or DIV with b≠0 → BUSY with count=W. Every other op (including DIV b=0) computes and → DONE.
  - BUSY: one iteration per cycle, count decrements. count reaching 1 → DONE. Inputs are ignored.
  - DONE: valid=1, ready=0, outputs stable. Unconditionally → IDLE.
- Op behaviour:
  - ADD: W-bit sum plus carry.
  - SUB: a−b mod 2^W; carry=borrow.
  - XOR, AND: bitwise.
  - LSH/RSH: logical shift by full-width b; b≥W gives 0.
  - MUL: unsigned 2W-bit product, split {result_hi,result}.
  - DIV: unsigned quotient/remainder.
  - DIV with b=0: result all ones, result_hi=a, div0=1.
  - GETI, SET, GET, LOA, STR, don, look: pass-through, result=b.
- Outputs keep their last values except valid, which is a pulse. Flags are updated only when entering DONE.
- start while ready=0 is ignored, not queued.

## Timing
- start sampled at the end of cycle 0.
- Single-cycle ops: valid in cycle 1; ready=1 again in cycle 2.
- MUL/DIV: BUSY for cycles 1..W, valid in cycle W+1, ready in cycle W+2.
- DIV by zero: valid in cycle 1.
- Back-to-back: start may be asserted in the same cycle ready returns high. Maximum throughput is one op per 2 cycles.
- Reset (rst_n=0 at an edge) has priority over everything:
  - After the edge: state=IDLE, ready=1, valid=0, result=result_hi=0, carry=zero=div0=0.
  - Reset mid-BUSY discards the operation; no valid pulse is produced.

## Structure
- alu_pkg (successor to the definitions package) holds:
  - op_mne enum, 4-bit, same encodings: SUB=0, ADD=1, DIV=2, MUL=3, XOR=4, LSH=5, RSH=6, GETI=7, AND=8, SET=9, GET=10, LOA=11, STR=12, don=13, look=14.
  - Matching kXXX logic constants.
  - alu_state_t enum {IDLE, BUSY, DONE}.
- Sub-module iter_muldiv (parameter W):
  - Holds the accumulator/partial-remainder registers and the iteration step.
  - Controlled by load, step, and a mode bit; exposes hi/lo.
  - The top keeps the FSM, counter, single-cycle ops and flags.

## Test plan
All with W=8.
- ADD a=200, b=100 → valid in cycle 1: result=44, carry=1, zero=0. SUB a=5, b=5 → result=0, zero=1, carry=0.
- MUL a=200, b=3 → valid exactly in cycle 9: result=0x58, result_hi=0x02. ready=0 for cycles 1–9; start pulses during BUSY are ignored.
- DIV a=200, b=7 → cycle 9: result=28, result_hi=4. DIV a=9, b=0 → cycle 1: result=0xFF, result_hi=9, div0=1.
- LSH a=0x81, b=1 → 0x02. RSH a=0x81, b=8 → 0x00. LOA a=3, b=0x5A → result=0x5A.
- rst_n=0 at cycle 4 of a MUL → next cycle ready=1, all outputs 0; no valid pulse follows.
- Back-to-back: ADD accepted in cycle 0, MUL accepted in cycle 2 → valid pulses in cycles 1 and 11. W=16 variant: 300×300 → {result_hi,result}=90000, valid in cycle 17.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the ALU and its neighbours.
// Pure definitions, no logic and no latency.
// No flow control; consumers import what they need.
package alu_pkg;

  typedef enum logic [3:0] {
    SUB  = 4'd0,
    ADD  = 4'd1,
    DIV  = 4'd2,
    MUL  = 4'd3,
    XOR  = 4'd4,
    LSH  = 4'd5,
    RSH  = 4'd6,
    GETI = 4'd7,
    AND  = 4'd8,
    SET  = 4'd9,
    GET  = 4'd10,
    LOA  = 4'd11,
    STR  = 4'd12,
    don  = 4'd13,
    look = 4'd14
  } op_mne;

  localparam logic [3:0] kSUB  = 4'd0;
  localparam logic [3:0] kADD  = 4'd1;
  localparam logic [3:0] kDIV  = 4'd2;
  localparam logic [3:0] kMUL  = 4'd3;
  localparam logic [3:0] kXOR  = 4'd4;
  localparam logic [3:0] kLSH  = 4'd5;
  localparam logic [3:0] kRSH  = 4'd6;
  localparam logic [3:0] kGETI = 4'd7;
  localparam logic [3:0] kAND  = 4'd8;
  localparam logic [3:0] kSET  = 4'd9;
  localparam logic [3:0] kGET  = 4'd10;
  localparam logic [3:0] kLOA  = 4'd11;
  localparam logic [3:0] kSTR  = 4'd12;
  localparam logic [3:0] kDON  = 4'd13;
  localparam logic [3:0] kLOOK = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/multicycle_alu_iter_muldiv.sv
// Iterative datapath: shift-add multiply (mode=0) or restoring divide (mode=1).
// One iteration per load or step pulse; load also performs the first iteration.
// No handshake; the owning FSM decides when to load and step.
module iter_muldiv #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic [W-1:0] hi_q, lo_q, opnd_q;
  logic         mode_q;

  logic [W-1:0] cur_hi, cur_lo, cur_opnd;
  logic         cur_mode;
  logic [W:0]   mul_add, mul_sum, div_sh;
  logic [W-1:0] div_diff;
  logic         div_ge;
  logic [W-1:0] hi_d, lo_d;

  // Select the iteration source: freshly loaded operands, or the running state.
  // MUL keeps multiplier in lo and multiplicand in opnd; DIV keeps dividend in lo.
  always_comb begin
    cur_mode = mode_q;
    cur_hi   = hi_q;
    cur_lo   = lo_q;
    cur_opnd = opnd_q;
    if (load) begin
      cur_mode = mode;
      cur_hi   = '0;
      cur_lo   = mode ? a : b;
      cur_opnd = mode ? b : a;
    end
  end

  // One shift-add or restoring-subtract iteration on the selected source.
  always_comb begin
    mul_add  = cur_lo[0] ? {1'b0, cur_opnd} : '0;
    mul_sum  = {1'b0, cur_hi} + mul_add;
    div_sh   = {cur_hi, cur_lo[W-1]};
    div_ge   = (div_sh >= {1'b0, cur_opnd});
    div_diff = div_sh[W-1:0] - cur_opnd;
    if (cur_mode) begin
      hi_d = div_ge ? div_diff : div_sh[W-1:0];
      lo_d = {cur_lo[W-2:0], div_ge};
    end else begin
      hi_d = mul_sum[W:1];
      lo_d = {mul_sum[0], cur_lo[W-1:1]};
    end
  end

  // Iteration registers advance only on load or step, otherwise hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
    end else if (load || step) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= cur_opnd;
      mode_q <= cur_mode;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/multicycle_alu.sv
// Width-generic ALU: single-cycle ops plus W-iteration MUL/DIV.
// Latency: 1 cycle for single-cycle ops and DIV-by-zero, W+1 cycles for MUL/DIV.
// Backpressure: start is only sampled while ready=1; starts while busy are dropped.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int W = 8,
  localparam int CW = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         div0
);

  localparam logic [CW-1:0] kCntInit = CW'(W);
  localparam logic [CW-1:0] kCntOne  = CW'(1);
  localparam logic [W:0]    kWExt    = (W+1)'(W);

  alu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic [W-1:0]  result_hi_q, result_hi_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          div0_q, div0_d;

  logic          it_load, it_step, it_mode;
  logic [W-1:0]  it_hi, it_lo;

  logic [W:0]    add_w, sub_w;
  logic          shift_big;
  logic [W-1:0]  sc_res, sc_hi;
  logic          sc_carry, sc_div0;
  logic          is_iter_op;

  iter_muldiv #(.W(W)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (it_load),
    .step  (it_step),
    .mode  (it_mode),
    .a     (a),
    .b     (b),
    .hi    (it_hi),
    .lo    (it_lo)
  );

  assign add_w      = {1'b0, a} + {1'b0, b};
  assign sub_w      = {1'b0, a} - {1'b0, b};
  assign shift_big  = ({1'b0, b} >= kWExt);
  assign is_iter_op = (op == kMUL) || ((op == kDIV) && (b != '0));

  // Single-cycle results straight from the inputs; DIV here only means b==0.
  always_comb begin
    sc_res   = b;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_div0  = 1'b0;
    case (op)
      kADD: begin
        sc_res   = add_w[W-1:0];
        sc_carry = add_w[W];
      end
      kSUB: begin
        sc_res   = sub_w[W-1:0];
        sc_carry = sub_w[W];
      end
      kXOR:    sc_res = a ^ b;
      kAND:    sc_res = a & b;
      kLSH:    sc_res = shift_big ? '0 : (a << b);
      kRSH:    sc_res = shift_big ? '0 : (a >> b);
      kDIV: begin
        sc_res  = '1;
        sc_hi   = a;
        sc_div0 = 1'b1;
      end
      default: sc_res = b;
    endcase
  end

  // FSM next state; output registers change only on the transition into DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    div0_d      = div0_q;
    it_load     = 1'b0;
    it_step     = 1'b0;
    it_mode     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_iter_op) begin
            it_load = 1'b1;
            it_mode = (op == kDIV);
            cnt_d   = kCntInit;
            state_d = BUSY;
          end else begin
            result_d    = sc_res;
            result_hi_d = sc_hi;
            carry_d     = sc_carry;
            zero_d      = (sc_res == '0);
            div0_d      = sc_div0;
            state_d     = DONE;
          end
        end
      end
      BUSY: begin
        if (cnt_q == kCntOne) begin
          // Load did the first iteration, so all W are complete here.
          result_d    = it_lo;
          result_hi_d = it_hi;
          carry_d     = 1'b0;
          zero_d      = (it_lo == '0);
          div0_d      = 1'b0;
          state_d     = DONE;
        end else begin
          it_step = 1'b1;
          cnt_d   = cnt_q - kCntOne;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      div0_q      <= div0_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign valid     = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: W=8 directed + random ops, W=16 spot checks.
// Expected responses come from an integer-arithmetic model of the op set.
// Stimulus waits on ready; junk start pulses are driven while the DUT is busy.
module tb_multicycle_alu;

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       carry;
    logic       zero;
    logic       div0;
    int         lat;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic       ready, valid, carry, zero, div0;
  logic [7:0] result, result_hi;

  logic        start16 = 1'b0;
  logic [3:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, valid16, carry16, zero16, div016;
  logic [15:0] result16, result_hi16;

  multicycle_alu #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .valid(valid), .result(result), .result_hi(result_hi),
    .carry(carry), .zero(zero), .div0(div0)
  );

  multicycle_alu #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .ready(ready16), .valid(valid16), .result(result16), .result_hi(result_hi16),
    .carry(carry16), .zero(zero16), .div0(div016)
  );

  int checks = 0;
  int passes = 0;

  exp_t q[$];
  exp_t mon_e;
  int   exp_ready = 0;
  logic [7:0] last_res = '0, last_hi = '0;
  logic       last_c = 1'b0, last_z = 1'b0, last_d = 1'b0;

  task automatic check(input string name, input logic ok, input longint act, input longint expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: plain integer arithmetic over the opcode table.
  function automatic exp_t model(input int o, input int x, input int y);
    exp_t e;
    int r, h, p;
    r = y; h = 0; p = 0;
    e.carry = 1'b0; e.div0 = 1'b0; e.lat = 1; e.cyc = 0;
    case (o)
      0: begin r = (x - y + 256) % 256; e.carry = (x < y); end
      1: begin r = (x + y) % 256; e.carry = ((x + y) > 255); end
      2: begin
        if (y == 0) begin r = 255; h = x; e.div0 = 1'b1; end
        else begin r = x / y; h = x % y; e.lat = 9; end
      end
      3: begin p = x * y; r = p % 256; h = p / 256; e.lat = 9; end
      4: r = x ^ y;
      8: r = x & y;
      5: r = (y >= 8) ? 0 : ((x << y) % 256);
      6: r = (y >= 8) ? 0 : (x >> y);
      default: r = y;
    endcase
    e.res  = 8'(r);
    e.hi   = 8'(h);
    e.zero = (r == 0);
    return e;
  endfunction

  // Monitor: pop and compare on every valid; otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1'b0, 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("valid_cycle", cyc == mon_e.cyc, cyc, mon_e.cyc);
          check("result",    result == mon_e.res, result, mon_e.res);
          check("result_hi", result_hi == mon_e.hi, result_hi, mon_e.hi);
          check("carry",     carry == mon_e.carry, carry, mon_e.carry);
          check("zero",      zero == mon_e.zero, zero, mon_e.zero);
          check("div0",      div0 == mon_e.div0, div0, mon_e.div0);
          last_res = mon_e.res; last_hi = mon_e.hi;
          last_c = mon_e.carry; last_z = mon_e.zero; last_d = mon_e.div0;
        end
      end else begin
        check("hold_outputs",
              {result, result_hi, carry, zero, div0} == {last_res, last_hi, last_c, last_z, last_d},
              {result, result_hi, carry, zero, div0}, {last_res, last_hi, last_c, last_z, last_d});
      end
    end
  end

  task automatic issue(input int o, input int x, input int y);
    int guard;
    exp_t e;
    guard = 0;
    while (!ready && guard < 64) begin
      start = 1'b1;
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) begin
      check("ready_timeout", 1'b0, 0, 1);
      start = 1'b0;
      return;
    end
    check("ready_cycle", (guard > 0) ? (cyc == exp_ready) : (cyc >= exp_ready), cyc, exp_ready);
    e = model(o, x, y);
    e.cyc = cyc + e.lat;
    q.push_back(e);
    start = 1'b1; op = 4'(o); a = 8'(x); b = 8'(y);
    @(posedge clk); #1;
    start = 1'b0;
    exp_ready = e.cyc + 1;
  endtask

  task automatic run16(input int o, input int x, input int y, input longint expv);
    int t0, n;
    @(posedge clk); #1;
    start16 = 1'b1; op16 = 4'(o); a16 = 16'(x); b16 = 16'(y);
    t0 = cyc;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (!valid16 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("w16_valid_cycle", valid16 && (cyc == t0 + 17), cyc, t0 + 17);
    check("w16_value", {result_hi16, result16} == 32'(expv), {result_hi16, result16}, expv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int o, x, y, gap, guard;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_ready", ready == 1'b1, ready, 1);
    check("rst_valid", valid == 1'b0, valid, 0);
    check("rst_result", {result, result_hi} == 16'h0, {result, result_hi}, 0);
    check("rst_flags", {carry, zero, div0} == 3'b000, {carry, zero, div0}, 0);
    exp_ready = cyc;

    // Directed cases from the plan.
    issue(1, 200, 100);
    issue(0, 5, 5);
    issue(3, 200, 3);
    issue(2, 200, 7);
    issue(2, 9, 0);
    issue(5, 8'h81, 1);
    issue(6, 8'h81, 8);
    issue(11, 3, 8'h5A);
    issue(1, 255, 1);
    issue(3, 255, 255);
    issue(2, 5, 200);
    issue(1, 17, 4);
    issue(3, 200, 3);

    // Reset in cycle 4 of a MUL: operation dropped, outputs cleared.
    issue(3, 123, 45);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    last_res = '0; last_hi = '0; last_c = 1'b0; last_z = 1'b0; last_d = 1'b0;
    rst_n = 1'b1;
    check("midrst_ready", ready == 1'b1, ready, 1);
    check("midrst_outputs", {result, result_hi, carry, zero, div0} == 19'h0,
          {result, result_hi, carry, zero, div0}, 0);
    exp_ready = cyc;
    repeat (12) begin @(posedge clk); #1; end

    // Random ops with random gaps.
    for (int i = 0; i < 80; i++) begin
      o = $urandom_range(0, 14);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      if ((o == 5 || o == 6) && ($urandom_range(0, 3) != 0)) y = $urandom_range(0, 10);
      if (o == 2 && $urandom_range(0, 4) == 0) y = 0;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      issue(o, x, y);
    end

    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", q.size() == 0, q.size(), 0);

    run16(3, 300, 300, 64'd90000);
    run16(2, 60000, 7, (64'd3 << 16) | 64'd8571);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
